// File: rtl/core_seq_ctrl_if.sv
// Memory-side handshake bundle for core_seq_ctrl.
// Purpose: groups the instruction-fetch and data-access valid/ready signals and the gated
//          store enable, so they can be passed between the controller and the memories as one port.
// Modports:
//   master - sequencing controller: drives the requests, receives the ready/response signals
//   slave  - memory side: receives the requests, drives the ready/response signals
// Signals:
//   imem_req_valid/ready/addr  fetch request handshake and address
//   imem_resp_valid/inst       fetch response
//   dmem_req_valid/ready       data request handshake
//   dmem_resp_valid            data response (load data / store ack)
//   mem_wen                    gated store enable, travels with the data request
interface core_seq_ctrl_if #(
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned INST_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [PC_WIDTH-1:0]   imem_req_addr;
  logic                  imem_resp_valid;
  logic [INST_WIDTH-1:0] imem_resp_inst;
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_resp_valid;
  logic                  mem_wen;

  modport master (
    output imem_req_valid, imem_req_addr, dmem_req_valid, mem_wen,
    input  imem_req_ready, imem_resp_valid, imem_resp_inst, dmem_req_ready, dmem_resp_valid
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dmem_req_valid, mem_wen,
    output imem_req_ready, imem_resp_valid, imem_resp_inst, dmem_req_ready, dmem_resp_valid
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencing controller for the RV64 core datapath.
// Purpose: steps each instruction through fetch, execute, optional memory access and
//          write-back; owns the PC, retired-instruction count, ebreak halt and trap handling,
//          and gates the register-file and store write enables.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   bus               memory handshake bundle (master side)
//   inst              latched instruction for the decoder
//   dec_*             decoder classification of inst
//   next_pc_in        datapath next-PC (jal target or pc+4)
//   rf_wen            register-file write enable, only in write-back
//   pc                current instruction PC
//   retire, instret   retire pulse and 64-bit retired count
//   halted, trap      sticky status; trap_cause: 0 misaligned, 1 illegal, 2 fetch/3 data timeout
//   state             FSM state for debug
module core_seq_ctrl #(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter int unsigned          INST_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  PC_RST      = 64'h8000_0000,
  parameter int unsigned          MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  core_seq_ctrl_if.master       bus,
  output logic [INST_WIDTH-1:0] inst,
  input  logic                  dec_is_load,
  input  logic                  dec_is_store,
  input  logic                  dec_is_ebreak,
  input  logic                  dec_inst_not_ipl,
  input  logic                  dec_reg_wen,
  input  logic [PC_WIDTH-1:0]   next_pc_in,
  output logic                  rf_wen,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  retire,
  output logic [63:0]           instret,
  output logic                  halted,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StIwait = 3'd1,
    StExec  = 3'd2,
    StMem   = 3'd3,
    StDwait = 3'd4,
    StWb    = 3'd5,
    StHalt  = 3'd6,
    StTrap  = 3'd7
  } state_e;

  state_e      curState;
  logic [15:0] toutCnt;
  logic        toutHit;
  logic        fetchMisaligned;

  assign fetchMisaligned = pc[1:0] != 2'b00;
  // Last waiting cycle allowed; only acts when the state's exit condition is false.
  assign toutHit = (MEM_TIMEOUT != 0) && (toutCnt == 16'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      curState   <= StFetch;
      pc         <= PC_RST;
      inst       <= '0;
      instret    <= '0;
      halted     <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      toutCnt    <= '0;
    end else begin
      unique case (curState)
        StFetch: begin
          if (fetchMisaligned) begin
            curState   <= StTrap;
            trap       <= 1'b1;
            trap_cause <= 2'd0;
            toutCnt    <= '0;
          end else if (bus.imem_req_ready) begin
            curState <= StIwait;
            toutCnt  <= '0;
          end else if (toutHit) begin
            curState   <= StTrap;
            trap       <= 1'b1;
            trap_cause <= 2'd2;
            toutCnt    <= '0;
          end else begin
            toutCnt <= toutCnt + 16'd1;
          end
        end
        StIwait: begin
          if (bus.imem_resp_valid) begin
            inst     <= bus.imem_resp_inst;
            curState <= StExec;
            toutCnt  <= '0;
          end else if (toutHit) begin
            curState   <= StTrap;
            trap       <= 1'b1;
            trap_cause <= 2'd2;
            toutCnt    <= '0;
          end else begin
            toutCnt <= toutCnt + 16'd1;
          end
        end
        StExec: begin
          toutCnt <= '0;
          if (dec_inst_not_ipl) begin
            curState   <= StTrap;
            trap       <= 1'b1;
            trap_cause <= 2'd1;
          end else if (dec_is_ebreak) begin
            curState <= StHalt;
            halted   <= 1'b1;
            instret  <= instret + 64'd1;
          end else if (dec_is_load || dec_is_store) begin
            curState <= StMem;
          end else begin
            curState <= StWb;
          end
        end
        StMem: begin
          if (bus.dmem_req_ready) begin
            curState <= StDwait;
            toutCnt  <= '0;
          end else if (toutHit) begin
            curState   <= StTrap;
            trap       <= 1'b1;
            trap_cause <= 2'd3;
            toutCnt    <= '0;
          end else begin
            toutCnt <= toutCnt + 16'd1;
          end
        end
        StDwait: begin
          if (bus.dmem_resp_valid) begin
            curState <= StWb;
            toutCnt  <= '0;
          end else if (toutHit) begin
            curState   <= StTrap;
            trap       <= 1'b1;
            trap_cause <= 2'd3;
            toutCnt    <= '0;
          end else begin
            toutCnt <= toutCnt + 16'd1;
          end
        end
        StWb: begin
          pc       <= next_pc_in;
          instret  <= instret + 64'd1;
          curState <= StFetch;
          toutCnt  <= '0;
        end
        StHalt, StTrap: begin
          toutCnt <= '0;
        end
        default: curState <= StTrap;
      endcase
    end
  end

  // A misaligned PC never issues a fetch request.
  assign bus.imem_req_valid = (curState == StFetch) && !fetchMisaligned;
  assign bus.imem_req_addr  = pc;
  assign bus.dmem_req_valid = (curState == StMem);
  assign bus.mem_wen        = (curState == StMem) && dec_is_store;

  assign rf_wen = (curState == StWb) && dec_reg_wen;
  // ebreak retires directly from execute; illegal takes priority and never retires.
  assign retire = (curState == StWb) ||
                  ((curState == StExec) && !dec_inst_not_ipl && dec_is_ebreak);
  assign state  = curState;

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;
  localparam logic [63:0] PcRst = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        dec_is_load, dec_is_store, dec_is_ebreak, dec_inst_not_ipl, dec_reg_wen;
  logic [63:0] next_pc_in;
  logic        rf_wen;
  logic [63:0] pc;
  logic        retire;
  logic [63:0] instret;
  logic        halted, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  core_seq_ctrl_if #(.PC_WIDTH(64), .INST_WIDTH(32)) bus ();

  core_seq_ctrl #(
    .PC_WIDTH   (64),
    .INST_WIDTH (32),
    .PC_RST     (PcRst),
    .MEM_TIMEOUT(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .inst            (inst),
    .dec_is_load     (dec_is_load),
    .dec_is_store    (dec_is_store),
    .dec_is_ebreak   (dec_is_ebreak),
    .dec_inst_not_ipl(dec_inst_not_ipl),
    .dec_reg_wen     (dec_reg_wen),
    .next_pc_in      (next_pc_in),
    .rf_wen          (rf_wen),
    .pc              (pc),
    .retire          (retire),
    .instret         (instret),
    .halted          (halted),
    .trap            (trap),
    .trap_cause      (trap_cause),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  // Drive FETCH->IWAIT->EXEC with the given instruction word; returns in EXEC.
  task automatic fetch_to_exec(input logic [31:0] word);
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_inst  = word;
    tick();                        // now IWAIT
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    tick();                        // now EXEC
    bus.imem_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_inst = '0;
    bus.dmem_req_ready = 0; bus.dmem_resp_valid = 0;
    dec_is_load = 0; dec_is_store = 0; dec_is_ebreak = 0; dec_inst_not_ipl = 0; dec_reg_wen = 0;
    next_pc_in = '0;

    // Reset state
    do_reset(2);
    chk("rst_pc", pc, PcRst);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ivalid", 64'(bus.imem_req_valid), 64'd1);
    chk("rst_enables", {61'd0, rf_wen, bus.mem_wen, retire}, 64'd0);
    chk("rst_status", {62'd0, halted, trap}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);

    // ALU op: FETCH, IWAIT, EXEC, WB
    dec_reg_wen = 1'b1;
    next_pc_in  = 64'h8000_0004;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_inst = 32'h0000_0013;
    tick();
    chk("alu_iwait", 64'(state), 64'd1);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("alu_exec", 64'(state), 64'd2);
    chk("alu_inst", 64'(inst), 64'h13);
    chk("alu_exec_quiet", {62'd0, rf_wen, retire}, 64'd0);
    tick();
    chk("alu_wb", 64'(state), 64'd5);
    chk("alu_wb_pulse", {62'd0, rf_wen, retire}, 64'd3);
    chk("alu_wb_pc_hold", pc, PcRst);
    tick();
    chk("alu_fetch", 64'(state), 64'd0);
    chk("alu_pc", pc, 64'h8000_0004);
    chk("alu_instret", instret, 64'd1);
    chk("alu_after_quiet", {62'd0, rf_wen, retire}, 64'd0);

    // Store with dmem_req_ready low for 3 cycles
    dec_reg_wen  = 1'b0;
    dec_is_store = 1'b1;
    next_pc_in   = 64'h8000_0008;
    fetch_to_exec(32'h0000_2023);
    chk("st_exec", 64'(state), 64'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.dmem_req_ready = 1'b1;
      #1;
      chk("st_mem_req", {60'd0, state, bus.dmem_req_valid, bus.mem_wen, rf_wen},
          {60'd0, 3'd3, 1'b1, 1'b1, 1'b0});
      if (i < 3) tick();
    end
    tick();
    bus.dmem_req_ready = 1'b0;
    chk("st_dwait", {60'd0, state, bus.dmem_req_valid, bus.mem_wen, rf_wen},
        {60'd0, 3'd4, 1'b0, 1'b0, 1'b0});
    bus.dmem_resp_valid = 1'b1;
    tick();
    bus.dmem_resp_valid = 1'b0;
    chk("st_wb", {61'd0, state}, 64'd5);
    chk("st_wb_pulse", {62'd0, rf_wen, retire}, 64'd1);
    tick();
    chk("st_pc", pc, 64'h8000_0008);
    chk("st_instret", instret, 64'd2);
    dec_is_store = 1'b0;

    // ebreak: halts, retires once, no further fetches
    dec_is_ebreak = 1'b1;
    fetch_to_exec(32'h0010_0073);
    chk("eb_exec_retire", 64'(retire), 64'd1);
    chk("eb_exec_halted", 64'(halted), 64'd0);
    tick();
    chk("eb_halt", 64'(state), 64'd6);
    chk("eb_halted", 64'(halted), 64'd1);
    chk("eb_instret", instret, 64'd3);
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("eb_quiet", {60'd0, bus.imem_req_valid, retire, bus.dmem_req_valid, rf_wen}, 64'd0);
      tick();
    end
    chk("eb_still_halt", {61'd0, state}, 64'd6);
    chk("eb_instret_hold", instret, 64'd3);
    bus.imem_req_ready = 1'b0;

    // Illegal instruction (ebreak also set: illegal has priority)
    do_reset(1);
    chk("ill_rst_state", {61'd0, state}, 64'd0);
    chk("ill_rst_halted", 64'(halted), 64'd0);
    dec_inst_not_ipl = 1'b1;
    dec_reg_wen      = 1'b1;
    fetch_to_exec(32'hffff_ffff);
    chk("ill_exec_quiet", {62'd0, rf_wen, retire}, 64'd0);
    tick();
    chk("ill_state", 64'(state), 64'd7);
    chk("ill_trap", {61'd0, trap, trap_cause}, {61'd0, 1'b1, 2'd1});
    chk("ill_instret", instret, 64'd0);
    chk("ill_halted", 64'(halted), 64'd0);
    chk("ill_quiet", {62'd0, rf_wen, retire}, 64'd0);
    dec_inst_not_ipl = 1'b0;
    dec_is_ebreak    = 1'b0;
    dec_reg_wen      = 1'b0;
    do_reset(1);
    chk("ill_clear", {60'd0, state, trap}, 64'd0);
    chk("ill_clear_cause", 64'(trap_cause), 64'd0);

    // Fetch timeout: trap exactly 8 cycles after entering FETCH
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("ftout_wait", {60'd0, state, trap}, 64'd0);
    end
    tick();
    chk("ftout_state", 64'(state), 64'd7);
    chk("ftout_trap", {61'd0, trap, trap_cause}, {61'd0, 1'b1, 2'd2});
    chk("ftout_ivalid", 64'(bus.imem_req_valid), 64'd0);

    // Data side: acceptance on the last allowed cycle beats the timeout,
    // then a stalled response traps with cause 3
    do_reset(1);
    dec_is_load = 1'b1;
    fetch_to_exec(32'h0000_3003);
    tick();
    chk("dt_mem", 64'(state), 64'd3);
    for (int i = 1; i <= 7; i++) tick();
    chk("dt_mem_late", {60'd0, state, trap}, {60'd0, 3'd3, 1'b0});
    bus.dmem_req_ready = 1'b1;
    tick();
    bus.dmem_req_ready = 1'b0;
    chk("dt_progress", {60'd0, state, trap}, {60'd0, 3'd4, 1'b0});
    for (int i = 1; i <= 7; i++) tick();
    chk("dt_dwait_late", {60'd0, state, trap}, {60'd0, 3'd4, 1'b0});
    tick();
    chk("dt_trap", {60'd0, state, trap}, {60'd0, 3'd7, 1'b1});
    chk("dt_cause", 64'(trap_cause), 64'd3);
    dec_is_load = 1'b0;

    // Misaligned next PC: next FETCH traps with cause 0, no request
    do_reset(1);
    next_pc_in = 64'h8000_0002;
    fetch_to_exec(32'h0000_0013);
    tick();
    chk("mis_wb", 64'(state), 64'd5);
    tick();
    chk("mis_fetch", {61'd0, state}, 64'd0);
    chk("mis_pc", pc, 64'h8000_0002);
    chk("mis_ivalid", 64'(bus.imem_req_valid), 64'd0);
    bus.imem_req_ready = 1'b1;
    tick();
    chk("mis_trap", {60'd0, state, trap}, {60'd0, 3'd7, 1'b1});
    chk("mis_cause", 64'(trap_cause), 64'd0);
    chk("mis_ivalid_trap", 64'(bus.imem_req_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencing controller for the RV64 core datapath (PC register, decoder, register file, ALU, unified memory). It replaces the free-running "PC updates every cycle" scheme with an explicit FSM: fetch, execute, optional memory access, then write-back. The FSM talks to instruction and data memory over valid/ready handshakes and gates the register-file and memory write enables. It owns PC update, ebreak halt, illegal-instruction trap and memory-timeout trap.

Parameters:
PC_WIDTH, 64, width of PC and addresses
INST_WIDTH, 32, instruction width
PC_RST, 64'h8000_0000, PC value after reset
MEM_TIMEOUT, 255, max cycles waiting in any memory state before trapping; 0 disables; max 65535

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  fetch request accepted
imem_req_addr  out  PC_WIDTH  fetch address (= pc)
imem_resp_valid  in  1  fetch data valid
imem_resp_inst  in  INST_WIDTH  fetched instruction
inst  out  INST_WIDTH  latched instruction, drives decoder
dec_is_load  in  1  decoder: load
dec_is_store  in  1  decoder: store
dec_is_ebreak  in  1  decoder: ebreak
dec_inst_not_ipl  in  1  decoder: unimplemented instruction
dec_reg_wen  in  1  decoder: instruction writes rd
next_pc_in  in  PC_WIDTH  datapath next-PC (jal target or pc+4)
dmem_req_valid  out  1  data request
dmem_req_ready  in  1  data request accepted
dmem_resp_valid  in  1  data response (load data / store ack)
mem_wen  out  1  gated store enable
rf_wen  out  1  gated register-file write enable
pc  out  PC_WIDTH  current instruction PC
retire  out  1  one-cycle pulse per retired instruction
instret  out  64  retired instruction count
halted  out  1  sticky, set by ebreak
trap  out  1  sticky, set by trap condition
trap_cause  out  2  0 misaligned fetch, 1 illegal inst, 2 fetch timeout, 3 data timeout
state  out  3  FSM state encoding for debug

Behaviour:
- States: FETCH=0, IWAIT=1, EXEC=2, MEM=3, DWAIT=4, WB=5, HALT=6, TRAP=7.
- Reset (rst high at posedge, takes priority over everything): state=FETCH, pc=PC_RST, inst=0, instret=0, halted=0, trap=0, trap_cause=0. Combinational outputs follow FETCH: imem_req_valid=1, all others 0. Reset mid-operation abandons any transaction. Memories share the same rst, so no stale response survives.
- FETCH: imem_req_valid=1, imem_req_addr=pc. If pc[1:0]!=0, go to TRAP with cause 0 without issuing a request (valid=0 that cycle). On valid&&ready go to IWAIT. imem_resp_valid is ignored in FETCH.
- IWAIT: on imem_resp_valid, inst<=imem_resp_inst, go to EXEC. Minimum fetch latency: FETCH→EXEC in 2 cycles.
- EXEC: exactly 1 cycle; decoder inputs are sampled here. Priority order:
  - dec_inst_not_ipl → TRAP, cause 1.
  - dec_is_ebreak → HALT; retire=1 this cycle; instret+1.
  - load or store → MEM.
  - otherwise → WB.
- MEM: dmem_req_valid=1; mem_wen=dec_is_store, held every cycle until accepted. On valid&&ready go to DWAIT.
- DWAIT: on dmem_resp_valid go to WB.
- WB: 1 cycle. rf_wen=dec_reg_wen, retire=1, pc<=next_pc_in, instret<=instret+1 (wraps at 2^64), then → FETCH.
- rf_wen and mem_wen are never high outside WB and MEM respectively.
- HALT and TRAP: absorbing until rst. All request and enable outputs are 0. halted/trap stay 1. trap_cause holds.
- Timeout:
  - A 16-bit counter clears on every state change and increments each cycle spent in FETCH/IWAIT/MEM/DWAIT.
  - If MEM_TIMEOUT!=0, the counter equals MEM_TIMEOUT-1, and the state's exit condition is false, the FSM enters TRAP at the next edge: cause 2 from FETCH/IWAIT, cause 3 from MEM/DWAIT.
  - Progress in the same cycle beats timeout.
- Instruction cost: ALU/jal 4 cycles minimum; load/store 6 cycles minimum.

Test Plan:
- Reset: rst high 2 cycles → pc=0x8000_0000, state=0, imem_req_valid=1, rf_wen=mem_wen=retire=halted=trap=0, instret=0.
- ALU op, imem ready=1, resp 1 cycle after accept, dec_reg_wen=1, next_pc_in=0x8000_0004 → states 0,1,2,5; rf_wen and retire high only in cycle 4; pc=0x8000_0004 and instret=1 in cycle 5; FETCH again.
- Store, dmem_req_ready low 3 cycles then high, resp next cycle → dmem_req_valid and mem_wen high for 4 consecutive cycles; rf_wen never high; WB reached; instret=1.
- ebreak fetched → halted=1 after EXEC, retire pulses once, instret=1; imem_req_valid stays 0 for the next 100 cycles despite imem_req_ready=1.
- dec_inst_not_ipl=1 in EXEC → trap=1, trap_cause=1, no rf_wen/retire, instret=0. Then rst 1 cycle → state=FETCH, trap=0.
- MEM_TIMEOUT=8, imem_req_ready held 0 → trap=1, trap_cause=2 visible exactly 8 cycles after entering FETCH. Separately, next_pc_in=0x8000_0002 → next FETCH traps with cause 0 and imem_req_valid never asserts.
